fp_add_issue: RTL and testbench
===============================

// Module: fp_add_issue
// PURPOSE
//  Initiator/collector for the combinational single-precision add/sub datapath.
//  - Accepts operand requests over valid/ready and registers them.
//  - Holds the operands stable on the adder inputs for LATENCY cycles (multicycle path).
//  - Captures result+error into a result FIFO and returns them, tagged, over valid/ready.
//  - Sits between the FP issue stage and the FP add datapath.
// PARAMETERS
//  LATENCY  2  cycles operands are held before the result is sampled (>=1)
//  DEPTH    4  result FIFO entries (power of 2, >=2)
//  TAG_W    4  width of request tag carried to the result
// PORTS
//  clk          in   1      clock, all logic on rising edge
//  reset        in   1      synchronous, active-high reset
//  in_valid     in   1      request valid
//  in_ready     out  1      request accepted when in_valid&&in_ready at an edge
//  in_op1       in   32     fp_t operand 1
//  in_op2       in   32     fp_t operand 2
//  in_opcode    in   1      0=add, 1=sub (op1-op2)
//  in_tag       in   TAG_W  request tag
//  add_op1      out  32     registered operand 1 to adder
//  add_op2      out  32     registered operand 2 to adder
//  add_opcode   out  1      registered opcode to adder
//  add_result   in   32     adder result (comb. from add_op*)
//  add_error    in   1      adder error flag
//  out_valid    out  1      result valid (FIFO non-empty)
//  out_ready    in   1      consumer ready; pop on out_valid&&out_ready
//  out_result   out  32     head-of-FIFO result
//  out_error    out  1      head-of-FIFO error flag
//  out_tag      out  TAG_W  head-of-FIFO tag
//  busy         out  1      1 when in WAIT or FIFO non-empty
// BEHAVIOUR
//  - Reset (sync): state=IDLE, count=0, rd/wr ptr=0, add_op1/add_op2/add_opcode=0, tag reg=0.
//    out_valid=0, busy=0. in_ready=0 during any cycle reset is high.
//    In-flight request and all FIFO contents are discarded; no partial output afterwards.
//  - FSM IDLE: in_ready = (count < DEPTH) && !reset.
//    On accept: latch op1/op2/opcode/tag onto add_*; wait_cnt=LATENCY-1; ->WAIT.
//  - FSM WAIT: in_ready=0.
//    wait_cnt!=0: decrement.
//    wait_cnt==0: push {add_result, add_error, tag} at wr_ptr; wr_ptr++; ->IDLE.
//  - Timing: out_valid rises LATENCY edges after the accepting edge (FIFO was empty).
//    Next accept possible in the cycle after the push. Throughput = 1 per LATENCY+1 cycles.
//  - Space is reserved at accept (count<DEPTH checked), so a push never overflows.
//  - add_op* change only on accept, constant throughout WAIT.
//  - FIFO: first-word-fall-through. out_* = mem[rd_ptr], out_valid = (count!=0).
//    Pop: rd_ptr++.
//    Ptrs are log2(DEPTH) bits, wrap naturally DEPTH-1 -> 0.
//  - count next: +1 push only, -1 pop only, unchanged on simultaneous push+pop.
//  - Full (count==DEPTH): in_ready=0; a pop in the same cycle does not raise in_ready
//    until the next cycle (registered count).
//  - out_* undefined-but-stable when out_valid=0; bench must not check them.
//  - Results are returned strictly in acceptance order.
// TESTING
//  1. LATENCY=2, op1=0x3F800000, op2=0x40000000, add, tag=3, out_ready=1
//     -> out_valid 2 edges after accept, out_result=0x40400000, out_error=0, out_tag=3.
//  2. sub 0x40400000 - 0x3F800000, tag=5 -> out_result=0x40000000, out_tag=5.
//     Add_op* stable across the whole WAIT window.
//  3. out_ready=0, issue 5 requests (DEPTH=4)
//     -> in_ready low after 4th push. Raise out_ready: 4 results in order, tags 0..3.
//     5th accepted only after a pop.
//  4. FIFO wrap: 10 requests with out_ready toggling 1/0 each cycle
//     -> all 10 returned in order, count never >4, no drops/dups.
//  5. Assert reset in WAIT cycle with 2 entries queued
//     -> next cycle out_valid=0, busy=0, add_op*=0. Following request returns correct single result.
//  6. adder model forces add_error=1 for op1=0x7F800000 (Inf) - 0x7F800000
//     -> out_error=1 with matching tag.

Source files
------------

// File: rtl/fp_add_issue_if.sv
// Handshake bundle for fp_add_issue: request in, adder
// operands/result, tagged result out, plus busy status.
interface fp_add_issue_if #(
  parameter int TAG_W = 4
);
  // request side
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_op1;
  logic [31:0]      in_op2;
  logic             in_opcode;
  logic [TAG_W-1:0] in_tag;
  // adder side
  logic [31:0]      add_op1;
  logic [31:0]      add_op2;
  logic             add_opcode;
  logic [31:0]      add_result;
  logic             add_error;
  // result side
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic             out_error;
  logic [TAG_W-1:0] out_tag;
  // status
  logic             busy;

  modport slave (
    input  in_valid, in_op1, in_op2,
    input  in_opcode, in_tag,
    input  add_result, add_error,
    input  out_ready,
    output in_ready,
    output add_op1, add_op2, add_opcode,
    output out_valid, out_result,
    output out_error, out_tag,
    output busy
  );

  modport master (
    output in_valid, in_op1, in_op2,
    output in_opcode, in_tag,
    output add_result, add_error,
    output out_ready,
    input  in_ready,
    input  add_op1, add_op2, add_opcode,
    input  out_valid, out_result,
    input  out_error, out_tag,
    input  busy
  );
endinterface

// File: rtl/fp_add_issue.sv
// Issue/collect wrapper for a combinational FP add/sub
// datapath: registers a request, holds it on the adder
// for LATENCY cycles, then queues the tagged result in a
// first-word-fall-through FIFO.
// Ports: clk, reset (sync, active-high), io (slave view
// of fp_add_issue_if: in_*, add_*, out_*, busy).
module fp_add_issue #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4
) (
  input  logic           clk,
  input  logic           reset,
  fp_add_issue_if.slave  io
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WW-1:0]    r_wait;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [31:0]      r_op1;
  logic [31:0]      r_op2;
  logic             r_opcode;
  logic [TAG_W-1:0] r_tag;

  logic [31:0]      r_mem_res [DEPTH];
  logic             r_mem_err [DEPTH];
  logic [TAG_W-1:0] r_mem_tag [DEPTH];

  logic w_in_ready;
  logic w_accept;
  logic w_push;
  logic w_pop;
  logic w_has_room;
  logic w_nonempty;

  // Room is checked at accept, so the later push
  // can never overflow the FIFO.
  assign w_has_room = r_count < CW'(DEPTH);
  assign w_nonempty = r_count != '0;

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_push      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_in_ready = w_has_room && !reset;
        if (io.in_valid && w_in_ready)
          w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_wait == '0) begin
          w_push      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_accept = io.in_valid && w_in_ready;
  assign w_pop    = w_nonempty && io.out_ready;

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_wait <= '0;
    else if (w_accept)
      r_wait <= WW'(LATENCY - 1);
    else if (r_state == S_WAIT && r_wait != '0)
      r_wait <= r_wait - WW'(1);
  end

  // Operands change only on accept, so the adder
  // sees a stable input for the whole WAIT window.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op1    <= '0;
      r_op2    <= '0;
      r_opcode <= 1'b0;
      r_tag    <= '0;
    end else if (w_accept) begin
      r_op1    <= io.in_op1;
      r_op2    <= io.in_op2;
      r_opcode <= io.in_opcode;
      r_tag    <= io.in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_mem_res[r_wr_ptr] <= io.add_result;
      r_mem_err[r_wr_ptr] <= io.add_error;
      r_mem_tag[r_wr_ptr] <= r_tag;
    end
  end

  assign io.in_ready   = w_in_ready;
  assign io.add_op1    = r_op1;
  assign io.add_op2    = r_op2;
  assign io.add_opcode = r_opcode;
  assign io.out_valid  = w_nonempty;
  assign io.out_result = r_mem_res[r_rd_ptr];
  assign io.out_error  = r_mem_err[r_rd_ptr];
  assign io.out_tag    = r_mem_tag[r_rd_ptr];
  assign io.busy       = (r_state == S_WAIT) || w_nonempty;

endmodule

// File: tb/tb_fp_add_issue.sv
// Bench for fp_add_issue: behavioural FP adder model,
// scoreboard queue of expected tagged results.
module tb_fp_add_issue;
  localparam int LATENCY = 2;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fp_add_issue_if #(.TAG_W(TAG_W)) ifc();

  fp_add_issue #(
    .LATENCY(LATENCY),
    .DEPTH(DEPTH),
    .TAG_W(TAG_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .io(ifc.slave)
  );

  typedef struct {
    logic [31:0]      res;
    logic             err;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  bit acc;
  bit popd;

  function automatic logic [63:0] s2d(logic [31:0] s);
    int e;
    if (s[30:23] == 8'h00) return {s[31], 63'b0};
    e = int'(s[30:23]) - 127 + 1023;
    return {s[31], e[10:0], s[22:0], 29'b0};
  endfunction

  function automatic logic [31:0] d2s(logic [63:0] d);
    int e;
    if (d[62:52] == 11'h0) return {d[63], 31'b0};
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] i2f(int v);
    real r;
    r = v;
    return d2s($realtobits(r));
  endfunction

  // {error, result}; Inf/NaN operands flag an error.
  function automatic logic [32:0] fp_ref(
    logic [31:0] a, logic [31:0] b, logic sub);
    real ra, rb, r;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF)
      return {1'b1, 32'h7FC00000};
    ra = $bitstoreal(s2d(a));
    rb = $bitstoreal(s2d(b));
    r  = sub ? ra - rb : ra + rb;
    return {1'b0, d2s($realtobits(r))};
  endfunction

  always_comb begin
    {ifc.add_error, ifc.add_result} =
      fp_ref(ifc.add_op1, ifc.add_op2, ifc.add_opcode);
  end

  task automatic chk(string tag,
                     logic [63:0] obs,
                     logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic req(logic [31:0] a, logic [31:0] b,
                     logic sub, int tag);
    ifc.in_valid  = 1'b1;
    ifc.in_op1    = a;
    ifc.in_op2    = b;
    ifc.in_opcode = sub;
    ifc.in_tag    = TAG_W'(tag);
  endtask

  function automatic logic [31:0] rnd_f();
    int v;
    v = int'($urandom_range(0, 2000)) - 1000;
    return i2f(v);
  endfunction

  // Runs one clock: observe handshakes mid-cycle,
  // score pops, record accepts, end at edge+1.
  task automatic cycle();
    exp_t e;
    logic [32:0] r;
    acc  = 1'b0;
    popd = 1'b0;
    #4;
    if (ifc.in_ready)
      chk("room", 64'(q.size() < DEPTH), 64'(1));
    if (ifc.out_valid && ifc.out_ready) begin
      popd = 1'b1;
      chk("q_nonempty", 64'(q.size() != 0), 64'(1));
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("out_result", 64'(ifc.out_result), 64'(e.res));
        chk("out_error", 64'(ifc.out_error), 64'(e.err));
        chk("out_tag", 64'(ifc.out_tag), 64'(e.tag));
      end
    end
    if (ifc.in_valid && ifc.in_ready) begin
      r = fp_ref(ifc.in_op1, ifc.in_op2, ifc.in_opcode);
      e.err = r[32];
      e.res = r[31:0];
      e.tag = ifc.in_tag;
      q.push_back(e);
      acc = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(int max);
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    for (int i = 0; i < max; i++) begin
      if (q.size() == 0 && !ifc.busy) break;
      cycle();
    end
    chk("drained", 64'(q.size() == 0 && !ifc.busy), 64'(1));
  endtask

  initial begin
    int k;
    int first_pop;
    int fifth_acc;
    ifc.in_valid  = 1'b0;
    ifc.in_op1    = '0;
    ifc.in_op2    = '0;
    ifc.in_opcode = 1'b0;
    ifc.in_tag    = '0;
    ifc.out_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #4;
    chk("rst_in_ready", 64'(ifc.in_ready), 64'(0));
    @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(ifc.out_valid), 64'(0));
    chk("rst_busy", 64'(ifc.busy), 64'(0));
    chk("rst_add_op1", 64'(ifc.add_op1), 64'(0));
    reset = 1'b0;

    // 1: 1.0 + 2.0, result two edges after accept
    ifc.out_ready = 1'b1;
    req(32'h3F800000, 32'h40000000, 1'b0, 3);
    cycle();
    chk("t1_acc", 64'(acc), 64'(1));
    ifc.in_valid = 1'b0;
    chk("t1_ov_e0", 64'(ifc.out_valid), 64'(0));
    cycle();
    chk("t1_ov_e1", 64'(ifc.out_valid), 64'(0));
    cycle();
    chk("t1_ov_e2", 64'(ifc.out_valid), 64'(1));
    chk("t1_res", 64'(ifc.out_result), 64'(32'h40400000));
    chk("t1_err", 64'(ifc.out_error), 64'(0));
    chk("t1_tag", 64'(ifc.out_tag), 64'(3));
    cycle();
    chk("t1_pop", 64'(popd), 64'(1));

    // 2: 3.0 - 1.0, operands stable during WAIT
    req(32'h40400000, 32'h3F800000, 1'b1, 5);
    cycle();
    ifc.in_valid = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      chk("t2_op1", 64'(ifc.add_op1), 64'(32'h40400000));
      chk("t2_op2", 64'(ifc.add_op2), 64'(32'h3F800000));
      chk("t2_opc", 64'(ifc.add_opcode), 64'(1));
      cycle();
    end
    chk("t2_ov", 64'(ifc.out_valid), 64'(1));
    chk("t2_res", 64'(ifc.out_result), 64'(32'h40000000));
    chk("t2_tag", 64'(ifc.out_tag), 64'(5));
    drain(20);

    // 3: fill FIFO with consumer stalled
    ifc.out_ready = 1'b0;
    k = 0;
    for (int i = 0; i < 40 && k < 4; i++) begin
      req(rnd_f(), rnd_f(), 1'(($urandom() & 1)), k);
      cycle();
      if (acc) k++;
    end
    chk("t3_four_acc", 64'(k), 64'(4));
    req(rnd_f(), rnd_f(), 1'b0, 4);
    for (int i = 0; i < LATENCY + 2; i++) begin
      cycle();
      chk("t3_blocked", 64'(acc), 64'(0));
    end
    chk("t3_in_ready", 64'(ifc.in_ready), 64'(0));
    chk("t3_out_valid", 64'(ifc.out_valid), 64'(1));
    ifc.out_ready = 1'b1;
    first_pop = -1;
    fifth_acc = -1;
    for (int i = 0; i < 60; i++) begin
      if (k == 5 && q.size() == 0 && !ifc.busy) break;
      cycle();
      if (popd && first_pop < 0) first_pop = cyc;
      if (acc) begin
        k++;
        fifth_acc = cyc;
        ifc.in_valid = 1'b0;
      end
    end
    chk("t3_five_acc", 64'(k), 64'(5));
    chk("t3_acc_after_pop",
        64'(first_pop >= 0 && fifth_acc > first_pop), 64'(1));
    drain(20);

    // 4: wrap, consumer toggling every cycle
    k = 0;
    for (int i = 0; i < 300 && k < 10; i++) begin
      req(rnd_f(), rnd_f(), 1'(($urandom() & 1)), k);
      ifc.out_ready = 1'(i & 1);
      cycle();
      if (acc) k++;
    end
    chk("t4_ten_acc", 64'(k), 64'(10));
    drain(60);

    // 5: reset while WAIT with two entries queued
    ifc.out_ready = 1'b0;
    k = 0;
    for (int i = 0; i < 40 && k < 3; i++) begin
      req(rnd_f(), rnd_f(), 1'b0, 10 + k);
      cycle();
      if (acc) k++;
    end
    chk("t5_three_acc", 64'(k), 64'(3));
    ifc.in_valid = 1'b0;
    chk("t5_busy_pre", 64'(ifc.busy), 64'(1));
    reset = 1'b1;
    ifc.in_valid = 1'b1;
    #4;
    chk("t5_rst_in_ready", 64'(ifc.in_ready), 64'(0));
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    chk("t5_out_valid", 64'(ifc.out_valid), 64'(0));
    chk("t5_busy", 64'(ifc.busy), 64'(0));
    chk("t5_op1", 64'(ifc.add_op1), 64'(0));
    chk("t5_op2", 64'(ifc.add_op2), 64'(0));
    chk("t5_opc", 64'(ifc.add_opcode), 64'(0));
    q.delete();
    reset = 1'b0;
    req(32'h40000000, 32'h40000000, 1'b0, 9);
    cycle();
    chk("t5_acc", 64'(acc), 64'(1));
    drain(20);
    chk("t5_no_extra", 64'(ifc.out_valid), 64'(0));

    // 6: Inf - Inf flags an error
    req(32'h7F800000, 32'h7F800000, 1'b1, 6);
    cycle();
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b0;
    cycle();
    cycle();
    chk("t6_ov", 64'(ifc.out_valid), 64'(1));
    chk("t6_err", 64'(ifc.out_error), 64'(1));
    chk("t6_tag", 64'(ifc.out_tag), 64'(6));
    drain(20);

    // random traffic
    k = 0;
    for (int i = 0; i < 600 && k < 30; i++) begin
      if ($urandom_range(0, 3) != 0)
        req(rnd_f(), rnd_f(), 1'(($urandom() & 1)), k);
      else
        ifc.in_valid = 1'b0;
      ifc.out_ready = 1'($urandom_range(0, 1));
      cycle();
      if (acc) k++;
    end
    chk("rnd_acc", 64'(k), 64'(30));
    drain(80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end
endmodule
